// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU: interrupt sequencer states,
// the RETI opcode, the service-routine vector and the opcode field bounds.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        VECTOR,
        ISR,
        RESTORE,
        RETURN
    } int_state_t;

    localparam logic [4:0] OPC_RETI    = 5'b11111;
    localparam logic [7:0] VECTOR_ADDR = 8'hF0;
    localparam int         OPC_HI      = 23;
    localparam int         OPC_LO      = 19;

endpackage

// File: rtl/int_edge_latch.sv
// Registers the interrupt request and keeps a sticky pending flag set by a
// rising edge; a same-cycle set wins over clear.
module int_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic clr,
    output logic pending
);

    logic req_q;
    logic rise;

    assign rise = req & ~req_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            req_q   <= req;
            pending <= rise | (pending & ~clr);
        end
    end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt sequencer: squashes the front end, drains EX/DM/WB, vectors to
// the service routine and, on RETI, drains again and resumes at the saved PC.
module int_sequencer #(
    parameter int                ADDR_W       = 8,
    parameter int                INS_W        = 24,
    parameter logic [ADDR_W-1:0] VECTOR_ADDR  = ADDR_W'(cpu_pkg::VECTOR_ADDR),
    parameter int                DRAIN_CYCLES = 3,
    parameter logic [4:0]        RETI_OPCODE  = cpu_pkg::OPC_RETI
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              interrupt,
    input  logic              int_enable,
    input  logic [INS_W-1:0]  ins_id,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_pc,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              stall_pc,
    output logic              flush_if_id,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_addr,
    output logic [ADDR_W-1:0] epc,
    output logic              int_ack,
    output logic              in_isr
);

    import cpu_pkg::*;

    localparam int              CNT_W    = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    int_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pending;
    logic             take;
    logic             reti;
    logic             clr_pending;
    logic             unused_ins;

    int_edge_latch u_edge (
        .clk     (clk),
        .reset   (reset),
        .req     (interrupt),
        .clr     (clr_pending),
        .pending (pending)
    );

    assign take        = pending & int_enable & (state == IDLE);
    assign reti        = (state == ISR) & id_valid & (ins_id[OPC_HI:OPC_LO] == RETI_OPCODE);
    assign clr_pending = (state == VECTOR);
    assign unused_ins  = ^ins_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            epc   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Resume at the ID instruction unless ID holds a bubble
            if (take) begin
                epc <= id_valid ? id_pc : if_pc;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        stall_pc     = 1'b0;
        flush_if_id  = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = '0;
        int_ack      = 1'b0;
        in_isr       = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    stall_pc    = 1'b1;
                    flush_if_id = 1'b1;
                    cnt_nxt     = CNT_LOAD;
                    state_nxt   = DRAIN;
                end
            end
            DRAIN: begin
                stall_pc    = 1'b1;
                flush_if_id = 1'b1;
                if (cnt == '0) state_nxt = VECTOR;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            VECTOR: begin
                pc_load      = 1'b1;
                pc_load_addr = VECTOR_ADDR;
                int_ack      = 1'b1;
                flush_if_id  = 1'b1;
                state_nxt    = ISR;
            end
            ISR: begin
                in_isr = 1'b1;
                // RETI itself never reaches EX
                if (reti) begin
                    stall_pc    = 1'b1;
                    flush_if_id = 1'b1;
                    cnt_nxt     = CNT_LOAD;
                    state_nxt   = RESTORE;
                end
            end
            RESTORE: begin
                in_isr      = 1'b1;
                stall_pc    = 1'b1;
                flush_if_id = 1'b1;
                if (cnt == '0) state_nxt = RETURN;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            RETURN: begin
                pc_load      = 1'b1;
                pc_load_addr = epc;
                flush_if_id  = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: directed scenarios plus a randomized
// run against a cycle-count reference model.
module tb_int_sequencer;

    localparam int         D   = 3;
    localparam logic [7:0] VEC = 8'hF0;

    logic        clk = 1'b0;
    logic        reset, interrupt, int_enable, id_valid;
    logic [23:0] ins_id;
    logic [7:0]  id_pc, if_pc;
    logic        stall_pc, flush_if_id, pc_load, int_ack, in_isr;
    logic [7:0]  pc_load_addr, epc;
    logic [4:0]  outs;

    int total = 0;
    int bad   = 0;

    assign outs = {stall_pc, flush_if_id, pc_load, int_ack, in_isr};

    always #5 clk = ~clk;

    int_sequencer #(
        .ADDR_W       (8),
        .INS_W        (24),
        .VECTOR_ADDR  (8'hF0),
        .DRAIN_CYCLES (D),
        .RETI_OPCODE  (5'b11111)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .interrupt    (interrupt),
        .int_enable   (int_enable),
        .ins_id       (ins_id),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .if_pc        (if_pc),
        .stall_pc     (stall_pc),
        .flush_if_id  (flush_if_id),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .epc          (epc),
        .int_ack      (int_ack),
        .in_isr       (in_isr)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic plain_ins();
        ins_id = {5'($urandom_range(0, 30)), 19'($urandom)};
    endtask

    // From the take cycle through the first ISR cycle
    task automatic run_take(input logic [7:0] exp_epc, input bit vec_pulse, input string tag);
        logic [4:0] exp_seq [0:5];
        logic [7:0] exp_addr;
        exp_seq = '{5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b01110, 5'b00001};
        for (int k = 0; k < 6; k++) begin
            interrupt = vec_pulse && (k == 4);
            mid();
            total++;
            if (outs !== exp_seq[k]) begin
                bad++;
                $display("FAIL %s_seq k=%0d outs got=%b exp=%b", tag, k, outs, exp_seq[k]);
            end
            if (k >= 4) begin
                exp_addr = (k == 4) ? VEC : 8'h00;
                total++;
                if ({pc_load_addr, epc} !== {exp_addr, exp_epc}) begin
                    bad++;
                    $display("FAIL %s_vec k=%0d addr/epc got=%h/%h exp=%h/%h",
                             tag, k, pc_load_addr, epc, exp_addr, exp_epc);
                end
            end
            next_cycle();
        end
        interrupt = 1'b0;
    endtask

    // From ISR: a few ordinary cycles, RETI, RESTORE, RETURN
    task automatic run_return(input logic [7:0] exp_ret, input string tag);
        int n = $urandom_range(2, 5);
        for (int k = 0; k < n; k++) begin
            id_valid = 1'($urandom_range(0, 1));
            plain_ins();
            if (k == n - 1) begin
                id_valid      = 1'b0;
                ins_id[23:19] = 5'h1F;
            end
            mid();
            total++;
            if (outs !== 5'b00001) begin
                bad++;
                $display("FAIL %s_isr k=%0d outs got=%b exp=%b", tag, k, outs, 5'b00001);
            end
            next_cycle();
        end
        id_valid = 1'b1;
        ins_id   = {5'h1F, 19'($urandom)};
        for (int k = 0; k < 1 + D; k++) begin
            mid();
            total++;
            if (outs !== 5'b11001) begin
                bad++;
                $display("FAIL %s_restore k=%0d outs got=%b exp=%b", tag, k, outs, 5'b11001);
            end
            next_cycle();
            plain_ins();
        end
        mid();
        total++;
        if ({outs, pc_load_addr} !== {5'b01100, exp_ret}) begin
            bad++;
            $display("FAIL %s_return outs/addr got=%b/%h exp=%b/%h", tag, outs, pc_load_addr, 5'b01100, exp_ret);
        end
        next_cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1; interrupt = 1'b0; int_enable = 1'b1; id_valid = 1'b1;
        ins_id = '0; id_pc = '0; if_pc = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        mid();
        total++;
        if ({outs, pc_load_addr, epc} !== 21'd0) begin
            bad++;
            $display("FAIL reset outs/addr/epc got=%b/%h/%h exp=0/0/0", outs, pc_load_addr, epc);
        end
        next_cycle();
    endtask

    task automatic test_basic();
        id_valid = 1'b1; int_enable = 1'b1; plain_ins();
        for (int p = 8'h10; p <= 8'h13; p++) begin
            id_pc = 8'(p); if_pc = 8'(p + 1);
            interrupt = (p == 8'h13);
            mid();
            total++;
            if (outs !== 5'b00000) begin
                bad++;
                $display("FAIL basic_pre pc=%h outs got=%b exp=%b", id_pc, outs, 5'b00000);
            end
            next_cycle();
        end
        interrupt = 1'b0; id_pc = 8'h14; if_pc = 8'h15;
        run_take(8'h14, 1'b0, "basic");
    endtask

    task automatic test_reti();
        run_return(8'h14, "reti");
        mid();
        total++;
        if (outs !== 5'b00000) begin
            bad++;
            $display("FAIL reti_idle outs got=%b exp=%b", outs, 5'b00000);
        end
        next_cycle();
    endtask

    task automatic test_bubble();
        id_valid = 1'b1; ins_id = {5'h1F, 19'($urandom)};
        mid();
        total++;
        if (outs !== 5'b00000) begin
            bad++;
            $display("FAIL reti_outside outs got=%b exp=%b", outs, 5'b00000);
        end
        next_cycle();
        plain_ins(); interrupt = 1'b1; id_valid = 1'b0;
        id_pc = 8'($urandom); if_pc = 8'h22;
        next_cycle();
        interrupt = 1'b0;
        run_take(8'h22, 1'b0, "bubble");
        run_return(8'h22, "bubble");
    endtask

    task automatic test_mask();
        logic [7:0] a = 8'($urandom);
        logic [7:0] b = 8'($urandom);
        id_valid = 1'b1; id_pc = a; interrupt = 1'b1;
        next_cycle();
        interrupt = 1'b0;
        run_take(a, 1'b0, "mask1");
        interrupt = 1'b1;
        mid();
        total++;
        if (outs !== 5'b00001) begin
            bad++;
            $display("FAIL mask_isr_edge outs got=%b exp=%b", outs, 5'b00001);
        end
        next_cycle();
        interrupt = 1'b0;
        run_return(a, "mask1");
        id_valid = 1'b1; id_pc = b;
        run_take(b, 1'b0, "mask2");
        run_return(b, "mask2");
    endtask

    task automatic test_enable();
        logic [7:0] c = 8'($urandom);
        int w = $urandom_range(3, 6);
        int_enable = 1'b0; id_valid = 1'b1; interrupt = 1'b1;
        next_cycle();
        interrupt = 1'b0;
        for (int k = 0; k < w; k++) begin
            mid();
            total++;
            if (outs !== 5'b00000) begin
                bad++;
                $display("FAIL enable_hold k=%0d outs got=%b exp=%b", k, outs, 5'b00000);
            end
            next_cycle();
        end
        int_enable = 1'b1; id_pc = c;
        run_take(c, 1'b0, "enable");
        run_return(c, "enable");
    endtask

    task automatic test_coalesce();
        logic [7:0] d = 8'($urandom);
        logic [7:0] e = 8'($urandom);
        logic [7:0] f = 8'($urandom);
        int acks = 0;
        int_enable = 1'b0; id_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            interrupt = (k % 2 == 0);
            next_cycle();
        end
        interrupt = 1'b0; int_enable = 1'b1; id_pc = d;
        run_take(d, 1'b0, "coalesce");
        for (int k = 0; k < 6; k++) begin
            mid();
            acks += int'(int_ack);
            next_cycle();
        end
        total++;
        if (acks !== 0) begin
            bad++;
            $display("FAIL coalesce_extra_ack got=%0d exp=0", acks);
        end
        run_return(d, "coalesce");
        mid();
        total++;
        if (outs !== 5'b00000) begin
            bad++;
            $display("FAIL coalesce_idle outs got=%b exp=%b", outs, 5'b00000);
        end
        next_cycle();
        id_pc = e; interrupt = 1'b1;
        next_cycle();
        interrupt = 1'b0;
        run_take(e, 1'b1, "collide1");
        run_return(e, "collide1");
        id_valid = 1'b1; id_pc = f;
        run_take(f, 1'b0, "collide2");
        run_return(f, "collide2");
    endtask

    task automatic test_reset_mid();
        int hits = 0;
        id_valid = 1'b1; id_pc = 8'($urandom); interrupt = 1'b1;
        next_cycle();
        interrupt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            reset = (k == 2);
            mid();
            total++;
            if (outs !== 5'b11000) begin
                bad++;
                $display("FAIL rstmid_pre k=%0d outs got=%b exp=%b", k, outs, 5'b11000);
            end
            next_cycle();
        end
        reset = 1'b0;
        mid();
        total++;
        if ({outs, pc_load_addr, epc} !== 21'd0) begin
            bad++;
            $display("FAIL rstmid_after outs/addr/epc got=%b/%h/%h exp=0/0/0", outs, pc_load_addr, epc);
        end
        next_cycle();
        for (int k = 0; k < 10; k++) begin
            mid();
            hits += int'(int_ack | pc_load);
            next_cycle();
        end
        total++;
        if (hits !== 0) begin
            bad++;
            $display("FAIL rstmid_ack_or_load got=%0d exp=0", hits);
        end
    endtask

    // Model: mode 0 idle, 1 entering (t cycles since take), 2 in routine, 3 leaving (t since RETI)
    task automatic test_random();
        int         mode = 0;
        int         t = 0;
        logic       pend = 1'b0;
        logic       prev = 1'b0;
        logic [7:0] m_epc = 8'h00;
        logic [4:0] e_outs;
        logic [7:0] e_addr;
        logic       take, reti;
        reset = 1'b1; interrupt = 1'b0;
        next_cycle();
        next_cycle();
        for (int c = 0; c < 3000; c++) begin
            interrupt  = ($urandom_range(0, 9) == 0);
            int_enable = ($urandom_range(0, 5) != 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            id_pc      = 8'($urandom);
            if_pc      = 8'($urandom);
            ins_id     = {($urandom_range(0, 4) == 0) ? 5'h1F : 5'($urandom), 19'($urandom)};
            reset      = (c == 0) ? 1'b0 : ($urandom_range(0, 299) == 0);
            take = (mode == 0) && pend && int_enable;
            reti = (mode == 2) && id_valid && (ins_id[23:19] == 5'h1F);
            e_addr = 8'h00;
            case (mode)
                0: e_outs = take ? 5'b11000 : 5'b00000;
                1: if (t <= D) e_outs = 5'b11000;
                   else begin e_outs = 5'b01110; e_addr = VEC; end
                2: e_outs = reti ? 5'b11001 : 5'b00001;
                default: if (t <= D) e_outs = 5'b11001;
                         else begin e_outs = 5'b01100; e_addr = m_epc; end
            endcase
            mid();
            total++;
            if ({outs, pc_load_addr, epc} !== {e_outs, e_addr, m_epc}) begin
                bad++;
                $display("FAIL random cyc=%0d outs/addr/epc got=%b/%h/%h exp=%b/%h/%h",
                         c, outs, pc_load_addr, epc, e_outs, e_addr, m_epc);
            end
            if (reset) begin
                mode = 0; t = 0; pend = 1'b0; prev = 1'b0; m_epc = 8'h00;
            end else begin
                pend = (interrupt & ~prev) | (pend & ~((mode == 1) && (t == D + 1)));
                prev = interrupt;
                case (mode)
                    0: if (take) begin mode = 1; t = 1; m_epc = id_valid ? id_pc : if_pc; end
                    1: if (t == D + 1) mode = 2; else t++;
                    2: if (reti) begin mode = 3; t = 1; end
                    default: if (t == D + 1) mode = 0; else t++;
                endcase
            end
            next_cycle();
        end
        reset = 1'b0;
        interrupt = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_reti();
        test_bubble();
        test_mask();
        test_enable();
        test_coalesce();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
